// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction and data requesters share one RAM.
// Data wins ties until an instruction waiter has seen STARVE_MAX data grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int SW =
    (STARVE_MAX < 8) ? 3 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [1:0] RS_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;

  logic dreq;
  logic acc;
  logic starved;

  assign dreq    = dREN | dWEN;
  assign acc     = (ramstate == RS_ACCESS);
  assign starved = iREN && (scnt_q == SMAX);

  assign iload = ramload;
  assign dload = ramload;

  // State and starve counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  // Arbitration, completion and abort transitions
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dreq && !starved)
          state_d = DSERV;
        else if (iREN)
          state_d = ISERV;
      end
      DSERV: begin
        if (!dreq || acc)
          state_d = IDLE;
      end
      ISERV: begin
        if (!iREN || acc)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Starve counter: counts data completions while an fetch waits
  always_comb begin
    scnt_d = scnt_q;
    if (!iREN)
      scnt_d = '0;
    else if (state_q == ISERV && acc)
      scnt_d = '0;
    else if (state_q == DSERV && acc && scnt_q != SMAX)
      scnt_d = scnt_q + 1'b1;
  end

  // RAM strobes, address mux and wait flags
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    unique case (state_q)
      DSERV: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~acc;
      end
      ISERV: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        iwait   = ~acc;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while an instruction request waits.
REQ-002 SHALL have port CLK  input  1  clock, rising-edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iREN  input  1  instruction-side read request.
REQ-005 SHALL have port iaddr  input  32  instruction address.
REQ-006 SHALL have port iwait  output  1  instruction transaction not complete.
REQ-007 SHALL have port iload  output  32  instruction read data.
REQ-008 SHALL have port dREN / dWEN  input  1 each  data read / write request.
REQ-009 SHALL have port daddr / dstore  input  32 each  data address / store data.
REQ-010 SHALL have port dwait  output  1  data transaction not complete.
REQ-011 SHALL have port dload  output  32  data read data.
REQ-012 SHALL have port ramREN / ramWEN  output  1 each  RAM read / write strobe.
REQ-013 SHALL have port ramaddr / ramstore  output  32 each  RAM address / write data.
REQ-014 SHALL have port ramload  input  32  RAM read data.
REQ-015 SHALL have port ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-016 SHALL implement FSM with states IDLE, DSERV, ISERV; RAM strobes driven only in DSERV/ISERV.
REQ-017 SHALL maintain starve counter scnt, 3 bits minimum, saturating at STARVE_MAX.
REQ-018 IDLE arbitration, registered: if (dREN|dWEN) and not (iREN and scnt==STARVE_MAX) -> DSERV; else if iREN -> ISERV; else stay IDLE.
REQ-019 DSERV SHALL drive ramaddr=daddr, ramstore=dstore; ramWEN=dWEN; ramREN=dREN & ~dWEN; write wins if both set.
REQ-020 ISERV SHALL drive ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-021 In IDLE, ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-022 iload and dload SHALL equal ramload combinationally at all times.
REQ-023 dwait SHALL be 0 only in DSERV with ramstate==ACCESS; otherwise 1. iwait is the same for ISERV.
REQ-024 On ramstate==ACCESS in DSERV/ISERV, the transaction SHALL complete that cycle and the next state SHALL be IDLE; there is no direct re-grant.
REQ-025 Minimum transaction latency SHALL be 2 cycles from request to wait-low: 1 arbitration cycle + 1 RAM cycle.
REQ-026 ramstate FREE, BUSY or ERROR in a serve state SHALL hold the state and the RAM outputs unchanged.
REQ-027 Request withdrawn mid-serve SHALL abort to IDLE next cycle with wait held 1: DSERV with dREN=dWEN=0, or ISERV with iREN=0.
REQ-028 scnt update on each data completion with iREN=1: scnt=min(scnt+1, STARVE_MAX).
REQ-029 scnt SHALL clear to 0 on instruction completion, or in any cycle with iREN=0.
REQ-030 Simultaneous iREN and data request in IDLE with scnt<STARVE_MAX SHALL grant data.
REQ-031 STARVE_MAX=0 SHALL give instruction strict priority.

Reset
REQ-032 nRST low SHALL immediately force state=IDLE, scnt=0, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, independent of CLK.
REQ-033 Reset asserted mid-transaction SHALL drop RAM strobes asynchronously; no completion is signalled.
REQ-034 After nRST rises, first arbitration SHALL occur on the first rising CLK edge.

Verification
REQ-035 Single read: dREN=1, daddr=0x100, ramstate=ACCESS on 2nd cycle, ramload=0xDEADBEEF -> cycle 1 ramREN=1, ramaddr=0x100; dwait=0 and dload=0xDEADBEEF that cycle; state IDLE next.
REQ-036 Contention: iREN=1 and dWEN=1 held, scnt=0, RAM ACCESS after 1 BUSY cycle -> data served first, ramWEN=1, ramstore=dstore, 3 cycles to dwait=0; instruction served next.
REQ-037 Starvation, STARVE_MAX=4: iREN held, data re-requests after each completion -> exactly 4 data completions, then ISERV; scnt returns to 0 after iwait=0.
REQ-038 Abort: in DSERV with ramstate=BUSY, drop dREN -> next cycle IDLE, ramREN=0, dwait remains 1.
REQ-039 Both dREN=dWEN=1 -> ramWEN=1, ramREN=0.
REQ-040 Async reset: assert nRST low mid-ISERV between edges -> ramREN=0 and iwait=1 immediately; after release with iREN=1, ISERV entered on first edge.
